// File: rtl/adder_tree_var_seq.sv
// adder_tree_var_seq: pipelined masked N-input adder tree with stall and grouped accumulation
module adder_tree_var_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN = 4,
  parameter int ACC_LEN = 4,
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int ACC_BITS = $clog2(ACC_LEN),
  localparam int OUT_WIDTH = DATA_WIDTH + LEVELS + ACC_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            i_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus,
  input  logic                         i_acc_mode,
  input  logic                         i_en,
  output logic                         o_valid,
  output logic [OUT_WIDTH-1:0]         o_data_bus
);
  genvar l, n;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [DATA_WIDTH+l-1:0] sum_q [NUM_IN>>l];
    logic vld_q, mode_q;
    if (l == 0) begin : g_in
      for (n = 0; n < NUM_IN; n++) begin : g_lane
        assign sum_q[n] = i_valid[n] ? i_data_bus[n*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
      assign vld_q = |i_valid;
      assign mode_q = i_acc_mode;
    end else begin : g_st
      always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else if (i_en) begin
          vld_q <= g_lvl[l-1].vld_q;
          mode_q <= g_lvl[l-1].mode_q;
          for (int k = 0; k < (NUM_IN >> l); k++)
            sum_q[k] <= {1'b0, g_lvl[l-1].sum_q[2*k]} + {1'b0, g_lvl[l-1].sum_q[2*k+1]};
        end
      end
    end
  end
  logic [OUT_WIDTH-1:0] tree_sum, acc_q, acc_d;
  logic [ACC_BITS-1:0] cnt_q;
  logic last;
  assign tree_sum = OUT_WIDTH'(g_lvl[LEVELS].sum_q[0]);
  assign last = cnt_q == ACC_BITS'(ACC_LEN - 1);
  always_comb acc_d = (cnt_q == '0 ? '0 : acc_q) + tree_sum;
  // a bypass sample abandons any partially built accumulation group
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      cnt_q <= '0;
    end else if (i_en) begin
      if (!g_lvl[LEVELS].vld_q) o_valid <= 1'b0;
      else if (!g_lvl[LEVELS].mode_q) begin
        o_data_bus <= tree_sum;
        o_valid <= 1'b1;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        o_valid <= last;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) o_data_bus <= acc_d;
      end
    end
  end
endmodule

// File: doc/adder_tree_var_seq.md
# adder_tree_var_seq

Pipelined, parametrised N-input unsigned adder tree with per-lane valid masking, a pipeline-wide enable/stall, and an optional accumulate mode that sums ACC_LEN consecutive tree results into one output. It generalises the two-input sequential adder to wide reductions and sits in the reduction network after multiplier arrays, feeding partial sums toward the output buffers.

## Interface
- DATA_WIDTH, 16, width of each input lane (unsigned)
- NUM_IN, 4, number of input lanes; power of 2, >= 2
- ACC_LEN, 4, tree results summed per output in accumulate mode; >= 2
- Derived: LEVELS = log2(NUM_IN); ACC_BITS = clog2(ACC_LEN); OUT_WIDTH = DATA_WIDTH + LEVELS + ACC_BITS

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- i_valid  input  NUM_IN  per-lane valid; bit k qualifies lane k
- i_data_bus  input  NUM_IN*DATA_WIDTH  lane k = [k*DATA_WIDTH +: DATA_WIDTH]
- i_acc_mode  input  1  0 = bypass (one output per accepted sample), 1 = accumulate
- i_en  input  1  pipeline advance enable; 0 = stall
- o_valid  output  1  result valid
- o_data_bus  output  OUT_WIDTH  result, zero-extended unsigned sum

## Operation
- Sample accepted on a cycle with rst=0, i_en=1 and |i_valid=1. Lanes with i_valid[k]=0 contribute 0.
- Accepted sample enters stage 1 tagged with valid=1 and i_acc_mode; if i_en=1 and no lane valid, a bubble (valid=0) enters.
- Tree: LEVELS register stages; stage j sums pairs from stage j-1, width grows by 1 bit per stage. Then one output stage.
- Output stage, when the tree's last stage advances with valid=1:
  - tag mode=0: o_data_bus <= tree sum (zero-extended), o_valid <= 1; accumulation count cleared, any partial group discarded.
  - tag mode=1: cnt==0: acc <= sum; else acc <= acc + sum. If cnt==ACC_LEN-1: o_data_bus <= final acc (incl. this sum), o_valid <= 1, cnt <= 0; else cnt <= cnt+1, o_valid <= 0.
  - Tree last stage advancing with valid=0: o_valid <= 0, acc/cnt unchanged.
- OUT_WIDTH guarantees no overflow: max result = NUM_IN*ACC_LEN*(2^DATA_WIDTH-1).
- Mode is per sample; toggling i_acc_mode only affects samples accepted afterwards.

## Timing
- Reset: all stage valids, o_valid and cnt = 0; acc and o_data_bus undefined (all-X). Reset has priority over i_en. Reset mid-accumulation discards partial group and all in-flight samples.
- Latency: result of a sample (bypass) or last sample of a group (accumulate) presents o_valid=1 exactly LEVELS+1 i_en=1 cycles after acceptance (NUM_IN=4: 3 cycles with no stalls).
- Stall (i_en=0): every register, including o_valid, o_data_bus, acc, cnt, holds; no input accepted. Resumes unchanged when i_en returns to 1.
- Handshake: a result is transferred on each rising edge where o_valid=1 and i_en=1; consumers must qualify o_valid with i_en (held valid during stall is not a new result).
- Throughput: one sample per i_en=1 cycle; back-to-back samples yield back-to-back bypass outputs.
- o_data_bus is don't-care whenever o_valid=0.

## Test plan
- DATA_WIDTH=8, NUM_IN=4, bypass: all lanes valid, data 255,255,255,255 at cycle 0 -> o_valid=1, o_data_bus=1020 at cycle 3, o_valid=0 at cycle 4.
- Partial valid: i_valid=4'b0101, lanes 10,20,30,40 -> 40 after 3 cycles; i_valid=0 cycle -> no output.
- Accumulate, ACC_LEN=4: four back-to-back samples with sums 1020,1,2,3 -> single o_valid at 3 cycles after 4th sample, o_data_bus=1026; o_valid=0 for the first three.
- Stall: accept sample (sum 100), drop i_en for 5 cycles after cycle 1 -> pipeline frozen, o_valid=1 with 100 on the 3rd i_en=1 cycle after acceptance; no duplicate transfer counted.
- Mode switch mid-group: two accumulate samples (sums 5,6) then bypass sample sum 7 -> output 7 only; following four accumulate samples of 1 -> 4 (partial 11 discarded).
- Reset mid-operation: rst at cycle 2 with samples in flight and cnt=2 -> o_valid=0 next edge, no stale result; next full accumulate group sums correctly from zero.
